findstr_match: RTL and testbench



---
 rtl/findstr_pkg.sv | 19 +
 rtl/findstr_byte_cmp.sv | 18 +
 rtl/findstr_match.sv | 74 +++++++
 tb/tb_findstr_match.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/findstr_pkg.sv
// findstr_pkg: shared types, default pattern and the case-fold helper used by
// the findstr_match keyword spotter and its per-byte comparator.
package findstr_pkg;

  typedef logic [7:0] byte_t;

  localparam int                           DEF_PAT_LEN = 6;
  localparam logic [8*DEF_PAT_LEN-1:0]     DEF_PATTERN = "Welcom";

  // Fold ASCII lower-case letters to upper case by clearing bit 5; every
  // other byte value passes through unchanged.
  function automatic byte_t to_upper_byte(input byte_t b);
    if (b >= 8'h61 && b <= 8'h7A) begin
      return b & 8'hDF;
    end
    return b;
  endfunction

endpackage

// File: rtl/findstr_byte_cmp.sv
// findstr_byte_cmp: single-byte equality check between a stream byte and a
// pattern byte. With FINDSTR_NOCASE_EN defined both sides are folded to upper
// case first; otherwise the compare is exact 8-bit.
module findstr_byte_cmp
  import findstr_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       eq
);

`ifdef FINDSTR_NOCASE_EN
  assign eq = (to_upper_byte(a) == to_upper_byte(b));
`else
  assign eq = (a == b);
`endif

endmodule

// File: rtl/findstr_match.sv
// findstr_match: byte-serial keyword spotter. Keeps a sliding window of the
// last PAT_LEN-1 accepted bytes, compares {window, data} against PATTERN on
// every accepted byte, pulses get_flag for one cycle per occurrence and keeps
// a saturating hit count on num. Overlapping occurrences are all counted.
// Optional case-insensitive compare: define FINDSTR_NOCASE_EN.
module findstr_match
  import findstr_pkg::*;
#(
  parameter int                       PAT_LEN = DEF_PAT_LEN,
  parameter logic [8*PAT_LEN-1:0]     PATTERN = DEF_PATTERN,
  parameter int                       CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dv,
  input  logic [7:0]       data,
  output logic [CNT_W-1:0] num,
  output logic             get_flag
);

  localparam int                 WIN_W    = 8 * (PAT_LEN - 1);
  localparam int                 FILL_W   = $clog2(PAT_LEN);
  localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(PAT_LEN - 1);
  localparam logic [CNT_W-1:0]   NUM_MAX  = '1;

  logic [WIN_W-1:0]     window;
  logic [FILL_W-1:0]    fill;
  logic [8*PAT_LEN-1:0] candidate;
  logic [PAT_LEN-1:0]   byte_eq;
  logic                 hit;

  // The incoming byte becomes the least significant (last matched) byte.
  assign candidate = {window, data};

  // One comparator per pattern byte; a match needs every byte to agree.
  for (genvar i = 0; i < PAT_LEN; i++) begin : g_cmp
    findstr_byte_cmp u_cmp (
      .a  (candidate[8*i +: 8]),
      .b  (PATTERN[8*i +: 8]),
      .eq (byte_eq[i])
    );
  end

  // The fill guard stops the cleared window from matching before a full
  // pattern's worth of bytes has arrived since reset.
  assign hit = dv && (&byte_eq) && (fill == FILL_MAX);

  // Slide the window and advance the saturating fill counter on each accepted byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window <= '0;
      fill   <= '0;
    end else if (dv) begin
      window <= candidate[WIN_W-1:0];
      if (fill != FILL_MAX) begin
        fill <= fill + 1'b1;
      end
    end
  end

  // Register the hit pulse and bump the saturating occurrence count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      get_flag <= 1'b0;
      num      <= '0;
    end else begin
      get_flag <= hit;
      if (hit && (num != NUM_MAX)) begin
        num <= num + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_findstr_match.sv
// tb_findstr_match: directed scoreboard bench for findstr_match. Stimulus
// pushes the hand-computed cycle and count of every expected get_flag pulse;
// a monitor pops and compares whenever the DUT raises get_flag.
// Expectations follow FINDSTR_NOCASE_EN when it is defined.
module tb_findstr_match;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             dv = 1'b0;
  logic [7:0]       data = 8'h00;
  logic [CNT_W-1:0] num;
  logic             get_flag;

  typedef struct {
    int cyc;
    int num;
  } exp_t;

  exp_t expQ[$];
  int   cycle = 0;
  int   assertCount = 0;
  int   failCount = 0;
  int   hitCount;

  findstr_match #(
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dv       (dv),
    .data     (data),
    .num      (num),
    .get_flag (get_flag)
  );

  // Free-running clock and an edge counter used to timestamp pulses.
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Drive one cycle of input; an expected hit is stamped with the edge that samples it.
  task automatic applyStimulus(input logic valid, input logic [7:0] b,
                               input bit expHit, input int expNum);
    exp_t e;
    @(negedge clk);
    dv   = valid;
    data = b;
    if (expHit) begin
      e.cyc = cycle + 1;
      e.num = expNum;
      expQ.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h78, 1'b0, 0);
  endtask

  task automatic sendString(input string s, input int hitNum);
    for (int i = 0; i < s.len(); i++) begin
      applyStimulus(1'b1, s[i], (hitNum > 0) && (i == s.len() - 1), hitNum);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    dv    = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_num", num, 0);
    checkOutput("reset_flag", get_flag, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name, input int expNum);
    idle(3);
    checkOutput({name, "_queue_left"}, expQ.size(), 0);
    checkOutput({name, "_num"}, num, expNum);
    expQ.delete();
  endtask

  function automatic bit longHit(input int i);
`ifdef FINDSTR_NOCASE_EN
    return (i == 16) || (i == 30) || (i == 44) || (i == 57) || (i == 77) || (i == 94);
`else
    return (i == 16) || (i == 44) || (i == 57) || (i == 94);
`endif
  endfunction

  // Monitor: every get_flag cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (get_flag) begin
      if (expQ.size() == 0) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL unexpected_pulse: got get_flag 1, expected 0 (cycle %0d, num %0d)", cycle, num);
      end else begin
        e = expQ.pop_front();
        checkOutput("pulse_cycle", cycle, e.cyc);
        checkOutput("pulse_num", num, e.num);
      end
    end
  end

  initial begin
    string longStr;
    longStr = "amgnawuiWelWelcomcomerighwelcomhbhhflalWelcomilrbgfvWelcomlailulwblsirudwelcomguufujijlawWelcomiurg";

    // Reset then idle
    $display("[TB] reset and idle");
    doReset();
    for (int i = 0; i < 10; i++) begin
      idle(1);
      checkOutput("idle_num", num, 0);
      checkOutput("idle_flag", get_flag, 0);
    end

    // Long mixed stream
    $display("[TB] long stream");
    doReset();
    hitCount = 0;
    for (int i = 0; i < longStr.len(); i++) begin
      if (longHit(i)) hitCount++;
      applyStimulus(1'b1, longStr[i], longHit(i), hitCount);
    end
`ifdef FINDSTR_NOCASE_EN
    drain("long", 6);
`else
    drain("long", 4);
`endif

    // dv gap inside a pattern
    $display("[TB] dv gap");
    doReset();
    sendString("Wel", 0);
    idle(3);
    sendString("com", 1);
    drain("gap", 1);

    // Saturation of num
    $display("[TB] saturation");
    doReset();
    for (int k = 1; k <= 17; k++) begin
      sendString("Welcom", (k > 15) ? 15 : k);
    end
    drain("sat", 15);

    // Reset in the middle of a pattern
    $display("[TB] reset mid-pattern");
    doReset();
    sendString("Welc", 0);
    doReset();
    sendString("om", 0);
    drain("midrst", 0);
    sendString("Welcom", 1);
    drain("midrst_after", 1);

    // Pattern starting on the first accepted byte after reset
    $display("[TB] early data");
    doReset();
    sendString("Welco", 0);
    @(negedge clk);
    dv = 1'b0;
    checkOutput("early_num_before", num, 0);
    sendString("m", 1);
    drain("early", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
